// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the data-memory responder.
// Holds the FSM state encoding and the default sizing of the block.
package dmem_pkg;

    localparam int DEF_NBITS   = 8;
    localparam int DEF_NWORDS  = 64;
    localparam int DEF_LATENCY = 2;

    // Wide enough for the largest legal LATENCY (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Datapath-to-memory bus for the data-memory responder.
// MemRead/MemWrite act as the request valid and stay asserted until Ready; Ready is a
// one-cycle completion strobe and Error qualifies the response only while Ready=1.
interface dmem_if #(
    parameter int NBITS = dmem_pkg::DEF_NBITS
);

    logic             MemRead;
    logic             MemWrite;
    logic [NBITS-1:2] Address;
    logic [NBITS-1:0] WriteData;
    logic [NBITS-1:0] ReadData;
    logic             Ready;
    logic             Error;

    modport master (
        output MemRead,
        output MemWrite,
        output Address,
        output WriteData,
        input  ReadData,
        input  Ready,
        input  Error
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Address,
        input  WriteData,
        output ReadData,
        output Ready,
        output Error
    );

endinterface

// File: rtl/dmem_lat_counter.sv
// Latency countdown for the data-memory responder: loadable down-counter with a zero flag.
// The count saturates at zero so it can be enabled for the whole wait phase.
module dmem_lat_counter
    import dmem_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read/write request, waits LATENCY cycles,
// then answers with a single-cycle Ready strobe carrying ReadData and Error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int NBITS   = DEF_NBITS,
    parameter int NWORDS  = DEF_NWORDS,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic   clock,
    input  logic   reset,
    dmem_if.slave  bus,
    output state_t dbg_state
);

    localparam int               AW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t           state;
    logic             rd_q;
    logic             wr_q;
    logic [NBITS-1:2] addr_q;
    logic [NBITS-1:0] wdata_q;
    logic [NBITS-1:0] rdata_q;
    logic             ready_q;
    logic             error_q;
    logic [NBITS-1:0] mem [NWORDS];

    logic             accept;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_en;
    logic             enter_resp;
    logic             commit;
    logic             acc_rd;
    logic             acc_wr;
    logic [NBITS-1:2] acc_addr;
    logic             acc_inr;
    logic [AW-1:0]    acc_idx;

    // In IDLE the access is still on the bus (needed when LATENCY=0 goes straight
    // to RESP); afterwards it comes from the captured registers.
    always_comb begin
        accept     = (state == IDLE) && (bus.MemRead || bus.MemWrite);
        acc_rd     = (state == IDLE) ? bus.MemRead  : rd_q;
        acc_wr     = (state == IDLE) ? bus.MemWrite : wr_q;
        acc_addr   = (state == IDLE) ? bus.Address  : addr_q;
        acc_inr    = (32'(acc_addr) < NWORDS);
        acc_idx    = AW'(acc_addr);
        enter_resp = (accept && (LATENCY == 0)) || ((state == WAIT) && cnt_zero);
        cnt_load   = accept && (LATENCY != 0);
        cnt_en     = (state == WAIT);
        commit     = (state == RESP) && acc_wr && !acc_rd && acc_inr;
    end

    dmem_lat_counter u_lat_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .enable   (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= enter_resp;
            error_q <= enter_resp && ((acc_rd && acc_wr) || !acc_inr);
            if (enter_resp && acc_rd && !acc_wr) begin
                rdata_q <= acc_inr ? mem[acc_idx] : '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q    <= bus.MemRead;
                        wr_q    <= bus.MemWrite;
                        addr_q  <= bus.Address;
                        wdata_q <= bus.WriteData;
                        state   <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Writes land on the edge leaving RESP, so a reset during the wait drops them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[acc_idx] <= wdata_q;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.Ready    = ready_q;
    assign bus.Error    = error_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2/64-word instance and a
// LATENCY=0/32-word instance, with a reference memory model feeding an expected queue.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_if #(.NBITS(8)) bus ();
    dmem_if #(.NBITS(8)) bus0 ();
    state_t dbg_state;
    state_t dbg_state0;

    dmem_responder #(.NBITS(8), .NWORDS(64), .LATENCY(2)) dut (
        .clock(clock), .reset(reset), .bus(bus), .dbg_state(dbg_state)
    );
    dmem_responder #(.NBITS(8), .NWORDS(32), .LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0), .dbg_state(dbg_state0)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [7:0] model_mem  [64];
    logic [7:0] model_mem0 [32];
    logic [7:0] last_rd;
    logic [7:0] last_rd0;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) model_mem0[i] = 8'h00;
        last_rd  = 8'h00;
        last_rd0 = 8'h00;
    endtask

    // Expected {Error, ReadData} of one access, updating the reference memory.
    task automatic predict(input bit s, input logic rd, input logic wr,
                           input logic [5:0] a, input logic [7:0] d);
        int         nw;
        logic       inr;
        logic       err;
        logic [7:0] cur;
        nw  = s ? 32 : 64;
        inr = (int'(a) < nw);
        err = (rd && wr) || !inr;
        cur = s ? last_rd0 : last_rd;
        if (rd && !wr) cur = !inr ? 8'h00 : (s ? model_mem0[a[4:0]] : model_mem[a]);
        if (wr && !rd && inr) begin
            if (s) model_mem0[a[4:0]] = d;
            else   model_mem[a] = d;
        end
        if (s) last_rd0 = cur;
        else   last_rd = cur;
        exp_q.push_back({err, cur});
    endtask

    task automatic set_bus(input bit s, input logic rd, input logic wr,
                           input logic [5:0] a, input logic [7:0] d);
        if (s) begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.Address = a; bus0.WriteData = d;
        end else begin
            bus.MemRead = rd; bus.MemWrite = wr; bus.Address = a; bus.WriteData = d;
        end
    endtask

    function automatic logic get_ready(input bit s);
        return s ? bus0.Ready : bus.Ready;
    endfunction

    function automatic logic [8:0] get_resp(input bit s);
        return s ? {bus0.Error, bus0.ReadData} : {bus.Error, bus.ReadData};
    endfunction

    // Holds the request until Ready, returning latency (negedges after drive), response
    // and {Ready, Error} one cycle later. Optional toggling disturbs the bus while waiting.
    task automatic drive_access(input bit s, input logic rd, input logic wr,
                                input logic [5:0] a, input logic [7:0] d, input bit toggle,
                                output int lat, output logic [8:0] obs, output logic [1:0] after);
        logic cur_wr;
        cur_wr = wr;
        @(negedge clock);
        set_bus(s, rd, wr, a, d);
        lat = -1;
        obs = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (get_ready(s)) begin
                lat = n;
                obs = get_resp(s);
                break;
            end
            if (toggle) begin
                cur_wr = ~cur_wr;
                set_bus(s, rd, cur_wr, a ^ 6'(n), ~d);
            end
        end
        set_bus(s, 1'b0, 1'b0, 6'd0, 8'h00);
        @(negedge clock);
        after = s ? {bus0.Ready, bus0.Error} : {bus.Ready, bus.Error};
    endtask

    task automatic access_and_check(input string name, input bit s, input logic rd,
                                    input logic wr, input logic [5:0] a, input logic [7:0] d,
                                    input bit toggle);
        int         lat;
        logic [8:0] obs;
        logic [8:0] exp;
        logic [1:0] after;
        predict(s, rd, wr, a, d);
        drive_access(s, rd, wr, a, d, toggle, lat, obs, after);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== (s ? 1 : 3)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, s ? 1 : 3);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s response {err,data}: got %h expected %h", name, obs, exp);
        end
        n_checks++;
        if (after !== 2'b00) begin
            n_fail++;
            $display("FAIL %s ready/error after strobe: got %b expected 00", name, after);
        end
    endtask

    task automatic test_reset();
        set_bus(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        set_bus(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        n_checks++;
        if ({bus.Ready, bus.Error, bus.ReadData} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset outputs: got %h expected 000", {bus.Ready, bus.Error, bus.ReadData});
        end
        n_checks++;
        if ({bus0.Ready, bus0.Error, bus0.ReadData} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset outputs lat0: got %h expected 000", {bus0.Ready, bus0.Error, bus0.ReadData});
        end
        n_checks++;
        if (dbg_state !== IDLE || dbg_state0 !== IDLE) begin
            n_fail++;
            $display("FAIL reset state: got %0d/%0d expected 0/0", dbg_state, dbg_state0);
        end
        reset = 1'b1;
    endtask

    task automatic test_write_then_read();
        int         lat;
        logic [8:0] obs;
        logic [1:0] after;
        access_and_check("wr_a5", 1'b0, 1'b0, 1'b1, 6'd5, 8'hA5, 1'b0);
        predict(1'b0, 1'b1, 1'b0, 6'd5, 8'h00);
        drive_access(1'b0, 1'b1, 1'b0, 6'd5, 8'h00, 1'b0, lat, obs, after);
        void'(exp_q.pop_front());
        n_checks++;
        if (lat !== 3 || obs !== 9'h0A5) begin
            n_fail++;
            $display("FAIL rd_a5: got lat %0d resp %h expected lat 3 resp 0a5", lat, obs);
        end
    endtask

    task automatic test_back_to_back();
        int         t1;
        int         t2;
        logic [8:0] o1;
        logic [8:0] o2;
        logic [8:0] e1;
        logic [8:0] e2;
        access_and_check("preload1", 1'b0, 1'b0, 1'b1, 6'd1, 8'h11, 1'b0);
        access_and_check("preload2", 1'b0, 1'b0, 1'b1, 6'd2, 8'h22, 1'b0);
        predict(1'b0, 1'b1, 1'b0, 6'd1, 8'h00);
        predict(1'b0, 1'b1, 1'b0, 6'd2, 8'h00);
        t1 = -1; t2 = -1; o1 = 'x; o2 = 'x;
        @(negedge clock);
        set_bus(1'b0, 1'b1, 1'b0, 6'd1, 8'h00);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (bus.Ready) begin
                if (t1 < 0) begin
                    t1 = n; o1 = get_resp(1'b0); bus.Address = 6'd2;
                end else begin
                    t2 = n; o2 = get_resp(1'b0); break;
                end
            end
        end
        set_bus(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        @(negedge clock);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_checks++;
        if (t1 !== 3 || (t2 - t1) !== 4) begin
            n_fail++;
            $display("FAIL b2b timing: got first %0d gap %0d expected 3 and 4", t1, t2 - t1);
        end
        n_checks++;
        if (o1 !== e1 || o1 !== 9'h011) begin
            n_fail++;
            $display("FAIL b2b first: got %h expected %h", o1, e1);
        end
        n_checks++;
        if (o2 !== e2 || o2 !== 9'h022) begin
            n_fail++;
            $display("FAIL b2b second: got %h expected %h", o2, e2);
        end
    endtask

    task automatic test_conflict();
        access_and_check("conflict", 1'b0, 1'b1, 1'b1, 6'd3, 8'hFF, 1'b0);
        access_and_check("rd_after_conflict", 1'b0, 1'b1, 1'b0, 6'd3, 8'h00, 1'b0);
    endtask

    task automatic test_wait_toggle();
        access_and_check("wr_toggled", 1'b0, 1'b0, 1'b1, 6'd10, 8'h3C, 1'b1);
        access_and_check("rd_neighbour", 1'b0, 1'b1, 1'b0, 6'd11, 8'h00, 1'b0);
        access_and_check("rd_neighbour2", 1'b0, 1'b1, 1'b0, 6'd8, 8'h00, 1'b0);
        access_and_check("rd_toggled", 1'b0, 1'b1, 1'b0, 6'd10, 8'h00, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic       saw;
        int         lat;
        logic [8:0] obs;
        logic [8:0] exp;
        @(negedge clock);
        set_bus(1'b0, 1'b0, 1'b1, 6'd7, 8'h5A);
        @(negedge clock);
        n_checks++;
        if (dbg_state !== WAIT) begin
            n_fail++;
            $display("FAIL midreset in wait: got state %0d expected %0d", dbg_state, WAIT);
        end
        reset = 1'b0;
        set_bus(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        #1;
        n_checks++;
        if (dbg_state !== IDLE || bus.Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset immediate: got state %0d ready %b expected 0 0", dbg_state, bus.Ready);
        end
        saw = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (bus.Ready || bus0.Ready) saw = 1'b1;
        end
        model_reset();
        predict(1'b0, 1'b1, 1'b0, 6'd7, 8'h00);
        reset = 1'b1;
        set_bus(1'b0, 1'b1, 1'b0, 6'd7, 8'h00);
        lat = -1; obs = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (bus.Ready) begin
                lat = n; obs = get_resp(1'b0); break;
            end
        end
        set_bus(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        @(negedge clock);
        exp = exp_q.pop_front();
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset ready during reset: got %b expected 0", saw);
        end
        n_checks++;
        if (lat !== 3 || obs !== exp || obs !== 9'h000) begin
            n_fail++;
            $display("FAIL midreset read7: got lat %0d resp %h expected lat 3 resp %h", lat, obs, exp);
        end
    endtask

    task automatic test_lat0_and_range();
        access_and_check("l0_wr4", 1'b1, 1'b0, 1'b1, 6'd4, 8'h77, 1'b0);
        access_and_check("l0_rd4", 1'b1, 1'b1, 1'b0, 6'd4, 8'h00, 1'b0);
        access_and_check("oor_wr40", 1'b1, 1'b0, 1'b1, 6'd40, 8'hEE, 1'b0);
        access_and_check("oor_rd40", 1'b1, 1'b1, 1'b0, 6'd40, 8'h00, 1'b0);
        access_and_check("alias_rd8", 1'b1, 1'b1, 1'b0, 6'd8, 8'h00, 1'b0);
        access_and_check("l0_conflict", 1'b1, 1'b1, 1'b1, 6'd4, 8'h01, 1'b0);
        access_and_check("l0_rd4_again", 1'b1, 1'b1, 1'b0, 6'd4, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        bit         s;
        int         op;
        logic [5:0] a;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            s  = bit'($urandom_range(0, 1));
            op = $urandom_range(0, 5);
            a  = 6'($urandom_range(0, 63));
            d  = 8'($urandom_range(0, 255));
            access_and_check("random", s, op != 1, op == 1 || op == 5 || op == 4, a, d, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_back_to_back();
        test_conflict();
        test_wait_toggle();
        test_mid_reset();
        test_lat0_and_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
